// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 Hz VGA raster timing. Publishes the pixel coordinate
//            bus to the colour stage and registers its colour together with
//            hsync/vsync/blank into one cycle-aligned DAC interface.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic [9:0]  i_red,
    input  logic [9:0]  i_green,
    input  logic [9:0]  i_blue,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic [9:0]  o_vga_r,
    output logic [9:0]  o_vga_g,
    output logic [9:0]  o_vga_b,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_blank_n,
    output logic        o_sync_n,
    output logic        o_frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        active;
    logic        hs_n;
    logic        vs_n;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster counters: h advances every strobe, v advances on each h wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 11'd1;
                end
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Decode the active window and the active-low sync pulses for the current position.
    always_comb begin
        active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n   = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        vs_n   = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    end

    // DAC output stage: colour and sync for one pixel land together, one strobe later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vga_r   <= '0;
            o_vga_g   <= '0;
            o_vga_b   <= '0;
            o_hs      <= 1'b1;
            o_vs      <= 1'b1;
            o_blank_n <= 1'b0;
        end else if (i_pix_en) begin
            o_vga_r   <= active ? i_red   : 10'd0;
            o_vga_g   <= active ? i_green : 10'd0;
            o_vga_b   <= active ? i_blue  : 10'd0;
            o_hs      <= hs_n;
            o_vs      <= vs_n;
            o_blank_n <= active;
        end
    end

    // Coordinates come straight off the counter flops so colour stages see clean timing.
    assign o_x      = h_cnt;
    assign o_y      = v_cnt;
    assign o_sync_n = 1'b0;

    // (H_ACTIVE, V_ACTIVE) occurs once per frame; it marks the end of the visible area.
    assign o_frame_tick = i_pix_en && (h_cnt == H_ACT) && (v_cnt == V_ACT);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench. Instance d uses the 640x480 timing;
//            instance s uses a shrunken raster (30x15) so whole frames fit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] d_x, d_y, s_x, s_y;
    logic [9:0]  d_r, d_g, d_b, s_r, s_g, s_b;
    logic        d_hs, d_vs, d_bn, d_sn, d_tk;
    logic        s_hs, s_vs, s_bn, s_sn, s_tk;
    logic [9:0]  d_red, s_red;
    logic [9:0]  lit_colour;

    assign d_red      = d_x[9:0];
    assign s_red      = s_x[9:0];
    assign lit_colour = 10'h3FF;

    vga_timing_gen d (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .i_red(d_red), .i_green(lit_colour), .i_blue(lit_colour),
        .o_x(d_x), .o_y(d_y), .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b),
        .o_hs(d_hs), .o_vs(d_vs), .o_blank_n(d_bn), .o_sync_n(d_sn),
        .o_frame_tick(d_tk)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) s (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .i_red(s_red), .i_green(lit_colour), .i_blue(lit_colour),
        .o_x(s_x), .o_y(s_y), .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b),
        .o_hs(s_hs), .o_vs(s_vs), .o_blank_n(s_bn), .o_sync_n(s_sn),
        .o_frame_tick(s_tk)
    );

    // Reference raster geometry for each instance (0 = d, 1 = s).
    int ha[2]  = '{640, 16};
    int hf[2]  = '{16, 4};
    int hsw[2] = '{96, 6};
    int hb[2]  = '{48, 4};
    int va[2]  = '{480, 8};
    int vf[2]  = '{10, 2};
    int vsw[2] = '{2, 2};
    int vb[2]  = '{33, 3};

    int         mh[2], mv[2];
    logic       e_hs[2], e_vs[2], e_bn[2];
    logic [9:0] e_r[2], e_g[2];

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int cyc   = 0;
    int ph    = 0;
    int hs_lo = 0, bn_hi = 0, first_hs = -1;
    int lit = 0, vs_lo = 0, last_tick = -1, ntick = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mv[k] = 0;
            e_hs[k] = 1'b1; e_vs[k] = 1'b1; e_bn[k] = 1'b0;
            e_r[k] = '0; e_g[k] = '0;
        end
    endtask

    task automatic model_adv();
        logic act;
        for (int k = 0; k < 2; k++) begin
            act     = (mh[k] < ha[k]) && (mv[k] < va[k]);
            e_bn[k] = act;
            e_hs[k] = !((mh[k] >= ha[k] + hf[k]) && (mh[k] < ha[k] + hf[k] + hsw[k]));
            e_vs[k] = !((mv[k] >= va[k] + vf[k]) && (mv[k] < va[k] + vf[k] + vsw[k]));
            e_r[k]  = act ? 10'(mh[k]) : 10'd0;
            e_g[k]  = act ? 10'h3FF : 10'd0;
            if (mh[k] == ha[k] + hf[k] + hsw[k] + hb[k] - 1) begin
                mh[k] = 0;
                if (mv[k] == va[k] + vf[k] + vsw[k] + vb[k] - 1) mv[k] = 0;
                else mv[k]++;
            end else begin
                mh[k]++;
            end
        end
    endtask

    task automatic check_one(input int k, input logic [10:0] x, input logic [10:0] y,
                             input logic hs, input logic vs, input logic bn, input logic sn,
                             input logic tk, input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b);
        chk("x", k, x, mh[k]);
        chk("y", k, y, mv[k]);
        chk("hs", k, hs, e_hs[k]);
        chk("vs", k, vs, e_vs[k]);
        chk("blank_n", k, bn, e_bn[k]);
        chk("sync_n", k, sn, 1'b0);
        chk("tick", k, tk, pix_en && (mh[k] == ha[k]) && (mv[k] == va[k]));
        chk("vga_r", k, r, e_r[k]);
        chk("vga_g", k, g, e_g[k]);
        chk("vga_b", k, b, e_g[k]);
    endtask

    // Aggregate measurements taken at each sample point.
    task automatic measure();
        if (ph == 1 && n >= 1 && n <= 800) begin
            if (!d_hs) hs_lo++;
            if (d_bn) bn_hi++;
            if (!d_hs && first_hs < 0) first_hs = n;
        end
        if (ph == 1 && n == 640) chk("r_after_x639", 0, d_r, 639);
        if (ph == 1 && n == 800) begin
            chk("x_wrap", 0, d_x, 0);
            chk("y_after_wrap", 0, d_y, 1);
        end
        if (ph == 3 && n == 1) begin
            chk("restart_x", 0, d_x, 1);
            chk("restart_y", 0, d_y, 0);
            chk("restart_blank_n", 0, d_bn, 1);
            chk("restart_r", 0, d_r, 0);
        end
        if (s_g == 10'h3FF) lit++;
        if (!s_vs) vs_lo++;
        if (s_tk) begin
            chk("tick_x", 1, s_x, 16);
            chk("tick_y", 1, s_y, 8);
            if (last_tick >= 0) begin
                chk("tick_period", 1, cyc - last_tick, (ph == 1) ? 450 : 900);
                if (ph == 1) begin
                    chk("lit_pixels", 1, lit, 128);
                    chk("vs_low_cycles", 1, vs_lo, 60);
                end
                ntick++;
            end
            last_tick = cyc;
            lit = 0;
            vs_lo = 0;
        end
    endtask

    // One clock: apply strobe, check both instances, then advance past the edge.
    task automatic step(input logic en);
        pix_en = en;
        #1;
        check_one(0, d_x, d_y, d_hs, d_vs, d_bn, d_sn, d_tk, d_r, d_g, d_b);
        check_one(1, s_x, s_y, s_hs, s_vs, s_bn, s_sn, s_tk, s_r, s_g, s_b);
        measure();
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (en) model_adv();
        n++;
        cyc++;
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset state with the strobe idle.
        for (int i = 0; i < 3; i++) step(1'b0);

        // Free-running strobe: one full line of d, two frames of s.
        rst_n = 1'b1;
        n = 0;
        ph = 1;
        for (int i = 0; i < 1000; i++) step(1'b1);
        chk("hs_low_count", 0, hs_lo, 96);
        chk("blank_n_high_count", 0, bn_hi, 640);
        chk("first_hs_low", 0, first_hs, 657);

        // Strobe toggling 0,1: half-rate advance, outputs hold on idle cycles.
        ph = 2;
        last_tick = -1;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            step(1'b1);
        end
        chk("ticks_seen", 1, ntick, 2);

        // Asynchronous reset mid-line, checked before the next clock edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_x", 0, d_x, 0);
        chk("async_y", 0, d_y, 0);
        chk("async_hs", 0, d_hs, 1);
        chk("async_vs", 0, d_vs, 1);
        chk("async_blank_n", 0, d_bn, 0);
        chk("async_r", 0, d_r, 0);
        chk("async_g", 0, d_g, 0);
        chk("async_x", 1, s_x, 0);
        chk("async_blank_n", 1, s_bn, 0);
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        n = 0;
        ph = 3;
        for (int i = 0; i < 40; i++) step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
